// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned DefAddrW = 5;
  localparam int unsigned DefDataW = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StReq   = 2'd1,
    StDrain = 2'd2
  } fetch_state_e;

  // Queue entry layout at the default widths; the top rebuilds the same layout
  // at its own parameter widths.
  typedef struct packed {
    logic [DefAddrW-1:0] pc;
    logic [DefDataW-1:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Memory read and decode handshake bundle for the instruction fetch unit.
interface instr_fetch_unit_if #(
  parameter int unsigned ADDR_W = fetch_pkg::DefAddrW,
  parameter int unsigned DATA_W = fetch_pkg::DefDataW
) ();

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  logic              instr_valid;
  logic [DATA_W-1:0] instr_data;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_ready;

  // Fetch unit side
  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata,
    output instr_valid,
    output instr_data,
    output instr_pc,
    input  instr_ready
  );

  // Memory / decoder side
  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata,
    input  instr_valid,
    input  instr_data,
    input  instr_pc,
    output instr_ready
  );

endinterface

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched {pc, data} entries; flush wins over push/pop.
module fetch_queue #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 21
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic [Width-1:0]             wdata_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output logic [$clog2(Depth+1)-1:0]   count_o,
  output logic                         valid_o,
  output logic [Width-1:0]             head_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_pop;

  // Pop is ignored on an empty queue so a stray ready cannot underflow.
  assign do_pop = pop_i & (count_q != '0);

  // Next-state: pointers wrap naturally because Depth is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) begin
        mem_d[wr_ptr_q] = wdata_i;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push_i && !do_pop) begin
        count_d = count_q + 1'b1;
      end else if (!push_i && do_pop) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count_o = count_q;
  assign valid_o = (count_q != '0);
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch sequencer: reads instruction memory at the PC counter value, queues the
// words and hands {pc, instruction} pairs to decode. Redirects flush the queue
// and retire any request still owed by memory.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned Q_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc_in,
  output logic               pc_inc,
  output logic               pc_load,
  output logic [ADDR_W-1:0]  pc_load_val,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_addr,
  instr_fetch_unit_if.master bus
);

  localparam int unsigned CntW = $clog2(Q_DEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] data;
  } entry_t;

  fetch_state_e      state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

  logic              push;
  logic              pop;
  logic              q_valid;
  logic              q_full;
  logic [CntW-1:0]   q_count;
  entry_t            push_entry;
  entry_t            head_entry;

  assign q_full = (q_count == CntW'(Q_DEPTH));

  // FSM next-state. The request flop follows the next state so mem_req is
  // registered and independent of instr_ready.
  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    push       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!redirect_valid && !q_full) begin
          state_d    = StReq;
          mem_addr_d = pc_in;
        end
      end
      StReq: begin
        if (bus.mem_ack) begin
          // A same-cycle redirect makes this word stale, so it is dropped.
          state_d = StIdle;
          push    = !redirect_valid;
        end else if (redirect_valid) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (bus.mem_ack) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    mem_req_d = (state_d != StIdle);
  end

  // PC counter controls: advance only for words that actually enter the queue.
  always_comb begin
    pc_inc      = push;
    pc_load     = redirect_valid;
    pc_load_val = redirect_addr;
  end

  // FSM state, request strobe and address latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign pop             = q_valid & bus.instr_ready;
  assign push_entry.pc   = mem_addr_q;
  assign push_entry.data = bus.mem_rdata;

  fetch_queue #(
    .Depth (Q_DEPTH),
    .Width ($bits(entry_t))
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .count_o (q_count),
    .valid_o (q_valid),
    .head_o  (head_entry)
  );

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.instr_valid = q_valid;
  assign bus.instr_data  = head_entry.data;
  assign bus.instr_pc    = head_entry.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a PC counter, a variable-latency memory and a
// stream-level reference model of the delivered instruction sequence.
module tb_instr_fetch_unit;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] pc_in;
  logic          pc_inc;
  logic          pc_load;
  logic [AW-1:0] pc_load_val;
  logic          redirect_valid;
  logic [AW-1:0] redirect_addr;

  instr_fetch_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  instr_fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .Q_DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_in          (pc_in),
    .pc_inc         (pc_inc),
    .pc_load        (pc_load),
    .pc_load_val    (pc_load_val),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Environment / reference model state
  logic [DW-1:0] img [32];
  logic [AW-1:0] pc_model;
  logic [AW-1:0] exp_pc;
  int            mcnt;
  bit            discard;
  int            wait_cnt;
  int            lat;
  bit            prev_req, prev_ack, prev_rst;
  logic [AW-1:0] prev_addr;
  logic [AW-1:0] pop_log[$];
  logic [AW-1:0] req_log[$];
  int            n_inc, n_ack;
  bit            last_inc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: respond as memory, check, cross the edge, update the model.
  // Entered and left on the falling edge.
  task automatic tick();
    bit            ack, exp_inc, pop, req, inc, ld;
    logic [AW-1:0] ld_val, addr;
    req  = (bus.mem_req === 1'b1);
    addr = bus.mem_addr;
    if (!rst && req && wait_cnt >= lat) begin
      ack           = 1'b1;
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = img[addr];
    end else begin
      ack           = 1'b0;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 16'($urandom);
    end
    #1;
    exp_inc = !rst && req && ack && !redirect_valid && !discard;
    chk("pc_inc", pc_inc, exp_inc);
    chk("pc_load", pc_load, redirect_valid);
    if (redirect_valid) chk("pc_load_val", pc_load_val, redirect_addr);
    chk("instr_valid", bus.instr_valid, (mcnt != 0));
    if (prev_req && !prev_ack && !prev_rst && !rst && req) chk("mem_addr_hold", addr, prev_addr);
    pop = !rst && (mcnt != 0) && (bus.instr_ready === 1'b1) && !redirect_valid;
    if (pop) begin
      chk("instr_pc", bus.instr_pc, exp_pc);
      chk("instr_data", bus.instr_data, img[exp_pc]);
      pop_log.push_back(bus.instr_pc);
      exp_pc = exp_pc + 1'b1;
    end
    if (!rst && req && wait_cnt == 0 && !discard) begin
      chk("req_space", (mcnt < 2), 1'b1);
      req_log.push_back(addr);
    end
    ld       = pc_load;
    ld_val   = pc_load_val;
    inc      = pc_inc;
    last_inc = inc;
    if (inc) n_inc++;
    if (ack) n_ack++;
    @(posedge clk);
    if (ld) pc_model = ld_val;
    else if (inc) pc_model = pc_model + 1'b1;
    if (rst) begin
      mcnt    = 0;
      discard = 1'b0;
      exp_pc  = pc_model;
    end else if (redirect_valid) begin
      mcnt    = 0;
      discard = req && !ack;
      exp_pc  = redirect_addr;
    end else begin
      mcnt = mcnt + int'(exp_inc) - int'(pop);
      if (ack) discard = 1'b0;
    end
    wait_cnt  = (req && !ack && !rst) ? wait_cnt + 1 : 0;
    prev_req  = req;
    prev_ack  = ack;
    prev_rst  = rst;
    prev_addr = addr;
    @(negedge clk);
    pc_in          = pc_model;
    redirect_valid = 1'b0;
    bus.mem_ack    = 1'b0;
  endtask

  task automatic do_reset(input logic [AW-1:0] start);
    rst            = 1'b1;
    redirect_valid = 1'b0;
    bus.mem_ack    = 1'b0;
    pc_model       = start;
    pc_in          = start;
    repeat (2) @(negedge clk);
    rst      = 1'b0;
    mcnt     = 0;
    discard  = 1'b0;
    wait_cnt = 0;
    exp_pc   = start;
    prev_req = 1'b0;
    prev_ack = 1'b0;
    prev_rst = 1'b1;
    pop_log.delete();
    req_log.delete();
  endtask

  // Step until a fresh request to addr is on the bus (bounded).
  task automatic wait_for_req(input logic [AW-1:0] addr, input string tag);
    int k = 0;
    while (!(bus.mem_req === 1'b1 && bus.mem_addr === addr && wait_cnt == 0) && k < 40) begin
      tick();
      k++;
    end
    chk(tag, (k < 40), 1'b1);
  endtask

  task automatic wait_pops(input int n, input string tag);
    int k = 0;
    while (pop_log.size() < n && k < 60) begin
      tick();
      k++;
    end
    chk(tag, (k < 60), 1'b1);
  endtask

  function automatic logic [AW-1:0] pop_at(input int i);
    return (pop_log.size() > i) ? pop_log[i] : 'x;
  endfunction

  function automatic logic [AW-1:0] req_at(input int i);
    return (req_log.size() > i) ? req_log[i] : 'x;
  endfunction

  initial begin
    int i0, r0, k, len, pops0;
    for (int i = 0; i < 32; i++) img[i] = 16'($urandom);
    bus.instr_ready = 1'b1;
    bus.mem_rdata   = '0;
    redirect_addr   = '0;
    lat             = 0;
    n_inc           = 0;
    n_ack           = 0;

    // Reset values
    do_reset(5'd0);
    #1;
    chk("rst_mem_req", bus.mem_req, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 5'd0);
    chk("rst_instr_valid", bus.instr_valid, 1'b0);
    chk("rst_instr_data", bus.instr_data, 16'd0);
    chk("rst_instr_pc", bus.instr_pc, 5'd0);
    chk("rst_pc_inc", pc_inc, 1'b0);
    chk("rst_pc_load", pc_load, 1'b0);
    chk("rst_pc_load_val", pc_load_val, 5'd0);

    // Zero-wait streaming: request every other cycle, addresses 0,1,2,3
    for (int i = 0; i < 8; i++) begin
      chk("req_alternate", bus.mem_req, (i % 2));
      tick();
    end
    for (int i = 0; i < 4; i++) chk("stream_req_addr", req_at(i), i);
    for (int i = 0; i < 3; i++) chk("stream_pop_pc", pop_at(i), i);
    chk("inc_per_ack", n_inc, n_ack);

    // 3-cycle latency: request held 4 cycles, one pc_inc
    lat = 3;
    k   = 0;
    while (bus.mem_req !== 1'b1 && k < 10) begin tick(); k++; end
    i0  = n_inc;
    len = 0;
    while (bus.mem_req === 1'b1 && len < 20) begin tick(); len++; end
    chk("lat3_req_len", len, 4);
    chk("lat3_one_inc", n_inc - i0, 1);

    // Decoder stalled: exactly two fetches, then idle; resume at 2
    do_reset(5'd0);
    lat             = 0;
    bus.instr_ready = 1'b0;
    i0 = n_ack;
    repeat (12) tick();
    chk("stall_two_fetches", n_ack - i0, 2);
    chk("stall_no_req", bus.mem_req, 1'b0);
    r0 = req_log.size();
    bus.instr_ready = 1'b1;
    wait_pops(2, "stall_pop_wait");
    chk("stall_pop0", pop_at(0), 5'd0);
    chk("stall_pop1", pop_at(1), 5'd1);
    k = 0;
    while (req_log.size() == r0 && k < 20) begin tick(); k++; end
    chk("stall_resume_addr", req_at(r0), 5'd2);

    // Redirect to 0x14 while requesting addr 5, ack two cycles later
    do_reset(5'd4);
    bus.instr_ready = 1'b0;
    lat = 0;
    wait_for_req(5'd4, "redir_wait4");
    tick();
    lat = 2;
    wait_for_req(5'd5, "redir_wait5");
    i0 = n_inc;
    redirect_valid = 1'b1;
    redirect_addr  = 5'h14;
    tick();
    r0 = req_log.size();
    chk("redir_flush_empty", bus.instr_valid, 1'b0);
    k = 0;
    while (req_log.size() == r0 && k < 20) begin tick(); k++; end
    chk("redir_no_inc", n_inc - i0, 0);
    chk("redir_next_req", req_at(r0), 5'h14);
    bus.instr_ready = 1'b1;
    wait_pops(1, "redir_pop_wait");
    chk("redir_first_pop", pop_at(0), 5'h14);

    // Redirect and ack together, one entry queued, decoder ready
    do_reset(5'd8);
    bus.instr_ready = 1'b0;
    lat = 0;
    wait_for_req(5'd8, "same_wait8");
    tick();
    wait_for_req(5'd9, "same_wait9");
    bus.instr_ready = 1'b1;
    redirect_valid  = 1'b1;
    redirect_addr   = 5'h1c;
    tick();
    chk("same_no_inc", last_inc, 1'b0);
    chk("same_empty", bus.instr_valid, 1'b0);
    wait_pops(2, "same_pop_wait");
    chk("same_pop0", pop_at(0), 5'h1c);
    chk("same_pop1", pop_at(1), 5'h1d);

    // Address wrap 30, 31, 0
    do_reset(5'd30);
    lat = 1;
    wait_pops(3, "wrap_pop_wait");
    chk("wrap_pop0", pop_at(0), 5'd30);
    chk("wrap_pop1", pop_at(1), 5'd31);
    chk("wrap_pop2", pop_at(2), 5'd0);

    // Reset in the middle of a request
    lat = 5;
    k   = 0;
    while (!(bus.mem_req === 1'b1 && wait_cnt > 0) && k < 20) begin tick(); k++; end
    rst = 1'b1;
    tick();
    chk("midrst_mem_req", bus.mem_req, 1'b0);
    chk("midrst_instr_valid", bus.instr_valid, 1'b0);
    rst = 1'b0;

    // Randomized traffic against the stream model
    pops0 = pop_log.size();
    for (int c = 0; c < 1500; c++) begin
      bus.instr_ready = ($urandom_range(0, 3) != 0);
      lat = $urandom_range(0, 3);
      if ($urandom_range(0, 19) == 0) begin
        redirect_valid = 1'b1;
        redirect_addr  = 5'($urandom);
      end
      tick();
    end
    chk("random_progress", (pop_log.size() - pops0 > 100), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch sequencer that consumes the 5-bit program counter value and drives that counter's `load`/`inc` controls. It reads instruction memory through a req/ack handshake and buffers fetched words in a small queue. It presents `{pc, instruction}` pairs to the decoder through a valid/ready handshake. It sits between the PC counter and instruction memory on one side, and the decode stage on the other.

## Interface
Parameters:
- `ADDR_W`, 5, PC/memory address width (matches PC counter width)
- `DATA_W`, 16, instruction word width
- `Q_DEPTH`, 2, prefetch queue entries (power of two, ≥2)

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `pc_in`  in  ADDR_W  current PC counter output
- `pc_inc`  out  1  increment strobe to PC counter
- `pc_load`  out  1  load strobe to PC counter
- `pc_load_val`  out  ADDR_W  load value to PC counter
- `redirect_valid`  in  1  branch/jump redirect, single-cycle pulse
- `redirect_addr`  in  ADDR_W  redirect target
- `mem_req`  out  1  memory read request
- `mem_addr`  out  ADDR_W  read address, stable while `mem_req`=1
- `mem_ack`  in  1  read complete; `mem_rdata` valid this cycle
- `mem_rdata`  in  DATA_W  read data
- `instr_valid`  out  1  queue head valid
- `instr_data`  out  DATA_W  queue head instruction
- `instr_pc`  out  ADDR_W  queue head address
- `instr_ready`  in  1  decoder accepts head

## Operation
- FSM states:
  - IDLE: if `count < Q_DEPTH` and no redirect, latch `mem_addr <= pc_in`, go to REQ.
  - REQ: `mem_req`=1. On `mem_ack`: push `{mem_addr, mem_rdata}`, assert `pc_inc`, go to IDLE.
  - DRAIN: `mem_req`=1, outstanding request is still owed. On `mem_ack`: discard data, no `pc_inc`, go to IDLE.
- `count` counts queue occupancy only; one outstanding request maximum. No request is issued when full, so a push never overflows.
- `pc_inc`, `pc_load` and `pc_load_val` are combinational:
  - `pc_inc` = REQ & `mem_ack` & !`redirect_valid`.
  - `pc_load` = `redirect_valid`; `pc_load_val` = `redirect_addr`.
- Redirect, any state:
  - Flush the queue (`count` becomes 0; head invalid next cycle).
  - From REQ with no ack that cycle: go to DRAIN.
  - From REQ with ack that cycle: discard data, go to IDLE.
  - From DRAIN: stay in DRAIN. If ack arrives that cycle, go to IDLE.
  - From IDLE: stay in IDLE, no request that cycle.
- Redirect has priority over ack and over pop in the same cycle. A simultaneous `instr_ready` pop is absorbed by the flush.
- Pop: `instr_valid & instr_ready` advances the head. Push and pop in the same cycle leave `count` unchanged.
- Address wrap: PC 31 → 0 is owned by the counter. Fetch is agnostic, so `instr_pc` sequence …30, 31, 0, 1.
- `mem_addr` is held constant from IDLE→REQ until ack.
- Reset values: `mem_req` 0, `mem_addr` 0, `instr_valid` 0, `instr_data` 0, `instr_pc` 0, `pc_inc` 0, `pc_load` 0, `pc_load_val` 0, state IDLE, `count` 0.
- Reset mid-request abandons the handshake. The memory must tolerate `mem_req` dropping before ack.

## Timing
- Request issue: `mem_req` rises one cycle after IDLE with space. Sustained rate is one fetch per 2 cycles with zero-wait memory (ack in first REQ cycle).
- The counter updates on the same edge the data is pushed, so `pc_in` is current when IDLE samples it the following cycle.
- Fetch-to-decode latency: `instr_valid` rises the cycle after the ack edge.
- Redirect to first new-target request: 1 cycle from IDLE; from REQ/DRAIN, 1 cycle after the outstanding ack.
- Queue output is registered (head flops); no combinational path from `instr_ready` to `mem_req`.

## Structure
- Package `fetch_pkg`: FSM state enum (IDLE, REQ, DRAIN), default widths `ADDR_W`/`DATA_W`, queue entry struct `{pc, data}`.
- Sub-module `fetch_queue`: synchronous FIFO of `Q_DEPTH` entries with push, pop, flush, count, and head outputs. Flush has priority over push/pop.
- Top: FSM, address latch, PC control logic.

## Test plan
- Reset, then `pc_in`=0 with zero-wait memory and `instr_ready`=1 → `mem_addr` 0, 1, 2, … on every other cycle. Exactly one `pc_inc` per ack. `instr_pc`/`instr_data` match the memory image.
- `instr_ready`=0 → exactly 2 fetches occur, then `mem_req` stays 0. Raising `instr_ready` pops PCs 0, 1 in order and fetching resumes at 2.
- 3-cycle ack latency → `mem_addr` stable through all REQ cycles; no `pc_inc` before ack.
- Redirect to 0x14 while REQ at addr 5 with ack 2 cycles later → `pc_load`=1 with value 0x14 for one cycle. Queue is empty next cycle. The addr-5 data is discarded with no `pc_inc`. The next request is at 0x14.
- Redirect and ack in the same cycle, with the queue holding 1 entry and `instr_ready`=1 → no `pc_inc`, `count` 0, no entry pushed or duplicated.
- Start at PC 30 → `instr_pc` sequence 30, 31, 0. Asserting `rst` mid-REQ → `mem_req` 0 and `instr_valid` 0 the next cycle.
